ifu_fetch: RTL

//  Instruction-fetch stage directly downstream of the PC generator. Accepts PCs over a

---
 rtl/ifu_fetch.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/ifu_fetch.sv
// -----------------------------------------------------------------------------
// ifu_fetch : instruction-fetch stage between the PC generator and decode.
//   Accepts PCs over a valid/ready handshake, issues in-order reads to
//   instruction memory (req/gnt, then rvalid), tags each read with its PC and
//   buffers the returned {pc, instr} pairs in a small FIFO for decode.
//   A flush drops everything buffered and in flight; late responses to the
//   killed requests are swallowed in DRAIN.
//
// Ports
//   clk, rst                      clock, asynchronous active-high reset
//   pc_valid, pc_in, pc_ready     PC handshake (pc_ready = accepted this cycle)
//   flush                         redirect, kills all younger work
//   imem_req/addr/gnt             memory request channel
//   imem_rvalid/rdata             memory response channel (in order)
//   if_valid/pc/instr, if_ready   decode-side handshake on the FIFO head
//   if_misalign                   only with IFU_MISALIGN_CHK_EN
//
// Configuration
//   IFU_MISALIGN_CHK_EN : misaligned PCs bypass memory and enqueue a NOP
//                         tagged with if_misalign=1.
// -----------------------------------------------------------------------------
module ifu_fetch #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pc_valid,
    input  logic [ADDR_W-1:0] pc_in,
    output logic              pc_ready,
    input  logic              flush,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic              if_valid,
    output logic [ADDR_W-1:0] if_pc,
    output logic [DATA_W-1:0] if_instr,
    input  logic              if_ready
`ifdef IFU_MISALIGN_CHK_EN
    ,
    output logic              if_misalign
`endif
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned SUM_W = CNT_W + 1;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_DRAIN = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  inflight_q, inflight_d;
    logic [CNT_W-1:0]  discard_q, discard_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [PTR_W-1:0]  fifo_wr_q, fifo_wr_d, fifo_rd_q, fifo_rd_d;
    logic [PTR_W-1:0]  tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;
    logic [ADDR_W-1:0] tag_mem_q [DEPTH];
    logic [ADDR_W-1:0] tag_mem_d [DEPTH];
    logic [ADDR_W-1:0] fifo_pc_q [DEPTH];
    logic [ADDR_W-1:0] fifo_pc_d [DEPTH];
    logic [DATA_W-1:0] fifo_in_q [DEPTH];
    logic [DATA_W-1:0] fifo_in_d [DEPTH];
`ifdef IFU_MISALIGN_CHK_EN
    logic              fifo_mis_q [DEPTH];
    logic              fifo_mis_d [DEPTH];
`endif

    logic              credit;
    logic              misal;
    logic              direct;
    logic              issue;
    logic              push;
    logic              pop;
    logic [ADDR_W-1:0] push_pc;
    logic [DATA_W-1:0] push_instr;
    logic              push_mis;
    logic [CNT_W-1:0]  drain_left;

    // Request side: a slot exists for every outstanding read and buffered entry.
    assign credit = (SUM_W'(inflight_q) + SUM_W'(count_q)) < SUM_W'(DEPTH);
`ifdef IFU_MISALIGN_CHK_EN
    assign misal  = (pc_in[1:0] != 2'b00);
    // Misaligned PCs wait for older reads to return so program order holds.
    assign direct = pc_valid & credit & ~flush & (state_q == ST_RUN) & misal
                    & (inflight_q == '0);
`else
    assign misal  = 1'b0;
    assign direct = 1'b0;
`endif
    assign imem_req  = pc_valid & credit & ~flush & (state_q == ST_RUN) & ~misal;
    assign imem_addr = pc_in;
    assign issue     = imem_req & imem_gnt;
    assign pc_ready  = issue | direct;

    assign if_valid = (count_q != '0);
    assign if_pc    = fifo_pc_q[fifo_rd_q];
    assign if_instr = fifo_in_q[fifo_rd_q];
`ifdef IFU_MISALIGN_CHK_EN
    assign if_misalign = fifo_mis_q[fifo_rd_q];
`endif

    // Reads still owed by memory once this cycle's response is accounted for.
    assign drain_left = inflight_q - CNT_W'(imem_rvalid);

    // Next-state: FSM, tag queue, output FIFO and counters.
    always_comb begin
        state_d    = state_q;
        inflight_d = inflight_q;
        discard_d  = discard_q;
        count_d    = count_q;
        fifo_wr_d  = fifo_wr_q;
        fifo_rd_d  = fifo_rd_q;
        tag_wr_d   = tag_wr_q;
        tag_rd_d   = tag_rd_q;
        tag_mem_d  = tag_mem_q;
        fifo_pc_d  = fifo_pc_q;
        fifo_in_d  = fifo_in_q;
`ifdef IFU_MISALIGN_CHK_EN
        fifo_mis_d = fifo_mis_q;
`endif
        push       = 1'b0;
        push_pc    = tag_mem_q[tag_rd_q];
        push_instr = imem_rdata;
        push_mis   = 1'b0;
        pop        = if_valid & if_ready & ~flush;

        case (state_q)
            ST_RUN: begin
                if (flush) begin
                    if (drain_left != '0) begin
                        state_d   = ST_DRAIN;
                        discard_d = drain_left;
                    end
                end else if (imem_rvalid) begin
                    push     = 1'b1;
                    tag_rd_d = tag_rd_q + PTR_W'(1);
                end else if (direct) begin
                    push       = 1'b1;
                    push_pc    = pc_in;
                    push_instr = DATA_W'(32'h0000_0013);
                    push_mis   = 1'b1;
                end
            end
            ST_DRAIN: begin
                // Responses to killed reads are dropped; further flushes are absorbed.
                if (imem_rvalid) begin
                    discard_d = discard_q - CNT_W'(1);
                    if (discard_q <= CNT_W'(1)) state_d = ST_RUN;
                end else if (discard_q == '0) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase

        if (issue) begin
            tag_mem_d[tag_wr_q] = pc_in;
            tag_wr_d            = tag_wr_q + PTR_W'(1);
        end
        inflight_d = inflight_q + CNT_W'(issue) - CNT_W'(imem_rvalid);

        if (push) begin
            fifo_pc_d[fifo_wr_q] = push_pc;
            fifo_in_d[fifo_wr_q] = push_instr;
`ifdef IFU_MISALIGN_CHK_EN
            fifo_mis_d[fifo_wr_q] = push_mis;
`endif
            fifo_wr_d = fifo_wr_q + PTR_W'(1);
        end
        if (pop) fifo_rd_d = fifo_rd_q + PTR_W'(1);
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);

        if (flush) begin
            fifo_wr_d = '0;
            fifo_rd_d = '0;
            tag_wr_d  = '0;
            tag_rd_d  = '0;
            count_d   = '0;
        end
    end

    // State registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_RUN;
            inflight_q <= '0;
            discard_q  <= '0;
            count_q    <= '0;
            fifo_wr_q  <= '0;
            fifo_rd_q  <= '0;
            tag_wr_q   <= '0;
            tag_rd_q   <= '0;
            tag_mem_q  <= '{default: '0};
            fifo_pc_q  <= '{default: '0};
            fifo_in_q  <= '{default: '0};
`ifdef IFU_MISALIGN_CHK_EN
            fifo_mis_q <= '{default: 1'b0};
`endif
        end else begin
            state_q    <= state_d;
            inflight_q <= inflight_d;
            discard_q  <= discard_d;
            count_q    <= count_d;
            fifo_wr_q  <= fifo_wr_d;
            fifo_rd_q  <= fifo_rd_d;
            tag_wr_q   <= tag_wr_d;
            tag_rd_q   <= tag_rd_d;
            tag_mem_q  <= tag_mem_d;
            fifo_pc_q  <= fifo_pc_d;
            fifo_in_q  <= fifo_in_d;
`ifdef IFU_MISALIGN_CHK_EN
            fifo_mis_q <= fifo_mis_d;
`endif
        end
    end

`ifndef IFU_MISALIGN_CHK_EN
    logic unused_push_mis;
    assign unused_push_mis = push_mis;
`endif

endmodule
